// File: rtl/paged_burst_mem_if.sv
// paged_burst_mem_if
// Bus-slave memory controller for the multiplexed address/data bus. An
// address phase that hits PAGE starts a BURST_LEN-beat read or write burst
// against a synchronous-read memory with RD_LAT cycles of read latency.
//
// Ports:
//   clk            bus clock, all state on the rising edge
//   resetH         synchronous active-high reset
//   AddrValid      address phase strobe
//   rw             1 = read, 0 = write (sampled with AddrValid)
//   AddrData_in    address on the address phase, write data on write beats
//   AddrData_out   read data to the bus (0 while AddrData_oe is low)
//   AddrData_oe    drive enable for AddrData_out
//   mem_Addr       memory word address (0 outside active beats)
//   mem_DataIn     memory write data (0 outside write beats)
//   mem_DataOut    memory read data, valid RD_LAT cycles after mem_rdEn
//   mem_rdEn       memory read strobe
//   mem_wrEn       memory write strobe
//   busy           high whenever the controller is not idle
//
// state | meaning
// IDLE  | waiting for an address phase that hits this page
// WRITE | one write beat per cycle, BURST_LEN cycles
// READ  | one read strobe per cycle, BURST_LEN cycles
// DRAIN | RD_LAT cycles for the last read data to reach the bus
module paged_burst_mem_if #(
    parameter int                 DATA_W    = 16,
    parameter int                 PAGE_W    = 4,
    parameter logic [PAGE_W-1:0]  PAGE      = 4'h2,
    parameter int                 BURST_LEN = 4,
    parameter int                 RD_LAT    = 0,
    parameter int                 WRAP      = 0
) (
    input  logic                       clk,
    input  logic                       resetH,
    input  logic                       AddrValid,
    input  logic                       rw,
    input  logic [DATA_W-1:0]          AddrData_in,
    output logic [DATA_W-1:0]          AddrData_out,
    output logic                       AddrData_oe,
    output logic [DATA_W-PAGE_W-1:0]   mem_Addr,
    output logic [DATA_W-1:0]          mem_DataIn,
    input  logic [DATA_W-1:0]          mem_DataOut,
    output logic                       mem_rdEn,
    output logic                       mem_wrEn,
    output logic                       busy
);

    localparam int OFS_W = DATA_W - PAGE_W;
    localparam int CNT_W = 5;
    localparam logic [OFS_W-1:0] WIN_MASK = OFS_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFS_W-1:0]   base_q, base_d;
    logic               page_hit;
    logic               last_beat;
    logic               drain_done;
    logic [OFS_W-1:0]   lin_addr;
    logic [OFS_W-1:0]   beat_addr;
    logic               rd_oe;

    assign page_hit   = (AddrData_in[DATA_W-1 -: PAGE_W] == PAGE);
    assign last_beat  = (cnt_q == CNT_W'(BURST_LEN - 1));
    assign drain_done = (cnt_q == CNT_W'(RD_LAT - 1));

    // Linear address wraps naturally at 2^OFS_W; wrap mode keeps the
    // BURST_LEN-aligned window of the base and only cycles the low bits.
    assign lin_addr  = base_q + OFS_W'(cnt_q);
    assign beat_addr = (WRAP != 0) ? ((base_q & ~WIN_MASK) | (lin_addr & WIN_MASK))
                                   : lin_addr;

    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_Addr   = '0;
        mem_DataIn = '0;
        mem_rdEn   = 1'b0;
        mem_wrEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (AddrValid && page_hit) begin
                    base_d  = AddrData_in[OFS_W-1:0];
                    cnt_d   = '0;
                    state_d = rw ? READ : WRITE;
                end
            end
            WRITE: begin
                mem_wrEn   = 1'b1;
                mem_Addr   = beat_addr;
                mem_DataIn = AddrData_in;
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                mem_rdEn = 1'b1;
                mem_Addr = beat_addr;
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = (RD_LAT > 0) ? DRAIN : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Read-valid tracks mem_rdEn through the memory latency so the bus is
    // driven exactly in the cycles the memory presents read data.
    if (RD_LAT == 0) begin : g_no_lat
        assign rd_oe = mem_rdEn;
    end else begin : g_lat
        logic [RD_LAT-1:0] vld_q;
        always_ff @(posedge clk) begin
            if (resetH) begin
                vld_q <= '0;
            end else begin
                vld_q <= (vld_q << 1) | RD_LAT'(mem_rdEn);
            end
        end
        assign rd_oe = vld_q[RD_LAT-1];
    end

    assign AddrData_oe  = rd_oe;
    assign AddrData_out = rd_oe ? mem_DataOut : '0;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_paged_burst_mem_if.sv
// Testbench for paged_burst_mem_if. Two instances share the bus inputs:
// dut0 is linear with RD_LAT=0, dut1 wraps with RD_LAT=2. Each has its own
// memory and its own reference model; expected beats are queued when the
// model accepts an address phase and checked by a negedge monitor.
module tb_paged_burst_mem_if;

    localparam int BL = 4;

    typedef struct {
        int        cyc;
        bit [11:0] addr;
        bit [15:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        resetH;
    logic        AddrValid;
    logic        rw;
    logic [15:0] AddrData_in;

    logic [15:0] ado_a [2];
    logic        oe_a  [2];
    logic [11:0] ma_a  [2];
    logic [15:0] mdi_a [2];
    logic [15:0] mdo_a [2];
    logic        rd_a  [2];
    logic        wr_a  [2];
    logic        bz_a  [2];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    item_t     wq [2][$];
    item_t     rq [2][$];
    item_t     oq [2][$];
    int        acc_c  [2] = '{-10, -10};
    int        free_c [2] = '{0, 0};
    bit [15:0] ref_m  [2][0:4095];
    bit [15:0] bus_hist [0:4095];

    bit [15:0] m0 [0:4095];
    bit [15:0] m1 [0:4095];
    bit [15:0] p1a, p1b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    paged_burst_mem_if #(.DATA_W(16), .PAGE_W(4), .PAGE(4'h2), .BURST_LEN(BL),
                         .RD_LAT(0), .WRAP(0)) dut0 (
        .clk(clk), .resetH(resetH), .AddrValid(AddrValid), .rw(rw),
        .AddrData_in(AddrData_in), .AddrData_out(ado_a[0]), .AddrData_oe(oe_a[0]),
        .mem_Addr(ma_a[0]), .mem_DataIn(mdi_a[0]), .mem_DataOut(mdo_a[0]),
        .mem_rdEn(rd_a[0]), .mem_wrEn(wr_a[0]), .busy(bz_a[0]));

    paged_burst_mem_if #(.DATA_W(16), .PAGE_W(4), .PAGE(4'h2), .BURST_LEN(BL),
                         .RD_LAT(2), .WRAP(1)) dut1 (
        .clk(clk), .resetH(resetH), .AddrValid(AddrValid), .rw(rw),
        .AddrData_in(AddrData_in), .AddrData_out(ado_a[1]), .AddrData_oe(oe_a[1]),
        .mem_Addr(ma_a[1]), .mem_DataIn(mdi_a[1]), .mem_DataOut(mdo_a[1]),
        .mem_rdEn(rd_a[1]), .mem_wrEn(wr_a[1]), .busy(bz_a[1]));

    // Memories: dut0 reads combinationally, dut1 through a 2-stage pipe.
    always @(posedge clk) begin
        if (wr_a[0]) m0[ma_a[0]] <= mdi_a[0];
        if (wr_a[1]) m1[ma_a[1]] <= mdi_a[1];
        p1a <= m1[ma_a[1]];
        p1b <= p1a;
    end
    assign mdo_a[0] = m0[ma_a[0]];
    assign mdo_a[1] = p1b;

    function automatic int lat(int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic bit [11:0] beat_addr(int d, bit [11:0] base, int i);
        int b;
        b = int'(base);
        if (d == 1) return 12'((b / BL) * BL + ((b + i) % BL));
        return 12'((b + i) % 4096);
    endfunction

    task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
        end
    endtask

    // Drive one bus cycle and advance the reference models.
    task automatic drive(bit av, bit r, bit [15:0] ad, bit rst);
        int now;
        bit [11:0] a;
        now = cyc;
        resetH      = rst;
        AddrValid   = av;
        rw          = r;
        AddrData_in = ad;
        bus_hist[now % 4096] = ad;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                while (wq[d].size() > 0 && wq[d][$].cyc > now) void'(wq[d].pop_back());
                while (rq[d].size() > 0 && rq[d][$].cyc > now) void'(rq[d].pop_back());
                while (oq[d].size() > 0 && oq[d][$].cyc > now) void'(oq[d].pop_back());
                if (free_c[d] > now + 1) free_c[d] = now + 1;
            end else if (av && ad[15:12] == 4'h2 && now >= free_c[d]) begin
                acc_c[d] = now;
                for (int i = 0; i < BL; i++) begin
                    a = beat_addr(d, ad[11:0], i);
                    if (r) begin
                        rq[d].push_back('{now + 1 + i, a, 16'h0});
                        oq[d].push_back('{now + 1 + i + lat(d), a, ref_m[d][a]});
                    end else begin
                        wq[d].push_back('{now + 1 + i, a, 16'h0});
                    end
                end
                free_c[d] = now + BL + 1 + (r ? lat(d) : 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic wr_burst(bit [15:0] addr, bit [15:0] d0);
        drive(1'b1, 1'b0, addr, 1'b0);
        for (int i = 0; i < BL; i++) drive(1'b0, 1'b0, d0 + 16'(i), 1'b0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                bit ew, er, eo;
                item_t it;
                chk("busy", d, 16'(bz_a[d]), 16'(cyc > acc_c[d] && cyc < free_c[d]));
                while (wq[d].size() > 0 && wq[d][0].cyc < cyc) begin
                    it = wq[d].pop_front();
                    chk("missed_wr", d, 16'(cyc), 16'(it.cyc));
                end
                while (rq[d].size() > 0 && rq[d][0].cyc < cyc) begin
                    it = rq[d].pop_front();
                    chk("missed_rd", d, 16'(cyc), 16'(it.cyc));
                end
                while (oq[d].size() > 0 && oq[d][0].cyc < cyc) begin
                    it = oq[d].pop_front();
                    chk("missed_oe", d, 16'(cyc), 16'(it.cyc));
                end
                ew = wq[d].size() > 0 && wq[d][0].cyc == cyc;
                er = rq[d].size() > 0 && rq[d][0].cyc == cyc;
                eo = oq[d].size() > 0 && oq[d][0].cyc == cyc;
                chk("wrEn", d, 16'(wr_a[d]), 16'(ew));
                chk("rdEn", d, 16'(rd_a[d]), 16'(er));
                chk("oe",   d, 16'(oe_a[d]), 16'(eo));
                if (ew) begin
                    it = wq[d].pop_front();
                    chk("wr_addr", d, 16'(ma_a[d]), 16'(it.addr));
                    chk("wr_data", d, mdi_a[d], bus_hist[cyc % 4096]);
                    ref_m[d][it.addr] = bus_hist[cyc % 4096];
                end
                if (er) begin
                    it = rq[d].pop_front();
                    chk("rd_addr", d, 16'(ma_a[d]), 16'(it.addr));
                end
                if (eo) begin
                    it = oq[d].pop_front();
                    chk("rd_data", d, ado_a[d], it.data);
                end
                if (!ew && !er) chk("addr_idle", d, 16'(ma_a[d]), 16'h0);
                if (!ew) chk("din_idle", d, mdi_a[d], 16'h0);
                if (!eo) chk("dout_idle", d, ado_a[d], 16'h0);
            end
        end
    end

    initial begin
        resetH = 1'b1;
        AddrValid = 1'b0;
        rw = 1'b0;
        AddrData_in = '0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 1'b1);
        idle(2);

        // Write hit then read back.
        wr_burst(16'h2010, 16'h00A0);
        idle(2);
        // Read; dut0 free at T5 so T6 hits it, dut1 free at T7.
        drive(1'b1, 1'b1, 16'h2010, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 16'h2012, 1'b0);
        drive(1'b1, 1'b1, 16'h2014, 1'b0);
        idle(10);

        // Page miss, write and read.
        wr_burst(16'h3010, 16'h0055);
        drive(1'b1, 1'b1, 16'h3010, 1'b0);
        idle(6);

        // Window-wrap boundary and top-of-memory boundary.
        wr_burst(16'h2012, 16'h00B0);
        idle(2);
        drive(1'b1, 1'b1, 16'h2010, 1'b0);
        idle(8);
        wr_burst(16'h2FFE, 16'h00C0);
        idle(2);
        drive(1'b1, 1'b1, 16'h2FFE, 1'b0);
        idle(8);
        drive(1'b1, 1'b1, 16'h2000, 1'b0);
        idle(8);

        // Reset in T2 of a write, then a normal burst.
        drive(1'b1, 1'b0, 16'h2020, 1'b0);
        drive(1'b0, 1'b0, 16'h00D0, 1'b0);
        drive(1'b0, 1'b0, 16'h00D1, 1'b1);
        drive(1'b0, 1'b0, 16'h00D2, 1'b0);
        idle(2);
        drive(1'b1, 1'b1, 16'h2020, 1'b0);
        idle(8);
        wr_burst(16'h2020, 16'h00E0);
        idle(2);
        drive(1'b1, 1'b1, 16'h2020, 1'b0);
        idle(8);

        // Random traffic, mostly page hits, including strobes while busy.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bit [3:0] pg;
                pg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h2;
                drive(1'b1, 1'($urandom), {pg, 12'($urandom)}, 1'b0);
            end else begin
                drive(1'b0, 1'($urandom), 16'($urandom), 1'b0);
            end
        end
        idle(12);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
